aes_round_sequencer: RTL and testbench

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

---
 rtl/aes_round_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: walks one block through its round-key requests and
// ALU operations (AddRoundKey / SubBytes / ShiftRows / MixColumns) and
// delivers the ciphertext with a one-cycle done pulse.
module aes_round_sequencer #(
   parameter int unsigned NROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         abort,
   input  logic [127:0] state_in,
   output logic         rk_req,
   output logic [3:0]   rk_round,
   input  logic [127:0] rk_in,
   input  logic         rk_valid,
   output logic         alu_start,
   output logic [1:0]   alu_op,
   output logic [127:0] alu_a,
   output logic [127:0] alu_b,
   input  logic [127:0] alu_result,
   input  logic         alu_valid,
   output logic         busy,
   output logic         done,
   output logic [127:0] state_out
);

   localparam int unsigned DW = 128;
   localparam int unsigned RW = 4;
   localparam int unsigned OW = 2;
   localparam logic [RW-1:0] LAST_RND = RW'(NROUNDS);

   localparam logic [OW-1:0] OP_ARK = 2'b00;
   localparam logic [OW-1:0] OP_SUB = 2'b01;
   localparam logic [OW-1:0] OP_SHR = 2'b10;
   localparam logic [OW-1:0] OP_MIX = 2'b11;

   // Reject round counts the 4-bit round counter and op table cannot express
   if (NROUNDS < 2 || NROUNDS > 14) begin : g_bad_nrounds
      $error("aes_round_sequencer: NROUNDS must be within 2..14");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_KEYREQ = 3'd1,
      S_ISSUE  = 3'd2,
      S_WAIT   = 3'd3,
      S_FINISH = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [RW-1:0] rnd_q, rnd_d;
   logic [OW-1:0] opi_q, opi_d;
   logic [DW-1:0] st_q, st_d;
   logic [DW-1:0] key_q, key_d;

   logic          rk_req_q, rk_req_d;
   logic [RW-1:0] rk_round_q, rk_round_d;
   logic          alu_start_q, alu_start_d;
   logic [OW-1:0] alu_op_q, alu_op_d;
   logic [DW-1:0] alu_a_q, alu_a_d;
   logic [DW-1:0] alu_b_q, alu_b_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [DW-1:0] state_out_q, state_out_d;

   logic [OW-1:0] cur_op_c;

   // Operation for a given round and position within that round
   function automatic logic [OW-1:0] op_of(input logic [RW-1:0] rnd,
                                           input logic [OW-1:0] opi);
      logic [OW-1:0] op;
      op = OP_ARK;
      if (rnd == '0) begin
         op = OP_ARK;
      end else if (rnd == LAST_RND) begin
         case (opi)
            2'd0:    op = OP_SUB;
            2'd1:    op = OP_SHR;
            default: op = OP_ARK;
         endcase
      end else begin
         case (opi)
            2'd0:    op = OP_SUB;
            2'd1:    op = OP_SHR;
            2'd2:    op = OP_MIX;
            default: op = OP_ARK;
         endcase
      end
      return op;
   endfunction

   assign cur_op_c = op_of(rnd_q, opi_q);

   // State and datapath registers; all outputs are registered here too
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rnd_q       <= '0;
         opi_q       <= '0;
         st_q        <= '0;
         key_q       <= '0;
         rk_req_q    <= 1'b0;
         rk_round_q  <= '0;
         alu_start_q <= 1'b0;
         alu_op_q    <= OP_ARK;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         state_out_q <= '0;
      end else begin
         state_q     <= state_d;
         rnd_q       <= rnd_d;
         opi_q       <= opi_d;
         st_q        <= st_d;
         key_q       <= key_d;
         rk_req_q    <= rk_req_d;
         rk_round_q  <= rk_round_d;
         alu_start_q <= alu_start_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         state_out_q <= state_out_d;
      end
   end

   // Next-state, round/op pointer and working-state update; abort wins
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      opi_d   = opi_q;
      st_d    = st_q;
      key_d   = key_q;
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  st_d    = state_in;
                  rnd_d   = '0;
                  opi_d   = '0;
                  state_d = S_KEYREQ;
               end
            end
            S_KEYREQ: begin
               if (rk_valid) begin
                  key_d   = rk_in;
                  state_d = S_ISSUE;
               end
            end
            S_ISSUE: begin
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (alu_valid) begin
                  st_d = alu_result;
                  if (cur_op_c == OP_ARK) begin
                     rnd_d   = rnd_q + 4'd1;
                     opi_d   = '0;
                     state_d = (rnd_q < LAST_RND) ? S_KEYREQ : S_FINISH;
                  end else begin
                     opi_d   = opi_q + 2'd1;
                     state_d = S_ISSUE;
                  end
               end
            end
            S_FINISH: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Output decode from the next state so registered outputs align with it
   always_comb begin
      rk_req_d    = (state_d == S_KEYREQ);
      rk_round_d  = rnd_d;
      alu_start_d = (state_d == S_ISSUE);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_FINISH);
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      state_out_d = state_out_q;
      if (state_d == S_ISSUE) begin
         alu_op_d = op_of(rnd_d, opi_d);
         alu_a_d  = st_d;
         alu_b_d  = key_d;
      end
      if (state_d == S_FINISH) begin
         state_out_d = st_d;
      end
   end

   assign rk_req    = rk_req_q;
   assign rk_round  = rk_round_q;
   assign alu_start = alu_start_q;
   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_out = state_out_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a reference AES ALU and AES-128 key
// schedule answer the DUT with randomized latencies; expected ciphertexts
// come from published AES-128 vectors.
module tb_aes_round_sequencer;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         abort;
   logic [127:0] state_in;
   logic         rk_req;
   logic [3:0]   rk_round;
   logic [127:0] rk_in;
   logic         rk_valid;
   logic         alu_start;
   logic [1:0]   alu_op;
   logic [127:0] alu_a;
   logic [127:0] alu_b;
   logic [127:0] alu_result;
   logic         alu_valid;
   logic         busy;
   logic         done;
   logic [127:0] state_out;

   aes_round_sequencer #(.NROUNDS(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .state_in(state_in), .rk_req(rk_req), .rk_round(rk_round),
      .rk_in(rk_in), .rk_valid(rk_valid), .alu_start(alu_start),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_valid(alu_valid), .busy(busy),
      .done(done), .state_out(state_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [127:0] pt;
      logic [127:0] key;
      logic [127:0] ct;
      int           alu_dly;
      int           rk_dly;
   } vec_t;

   int           total = 0;
   int           bad = 0;
   logic [127:0] exp_q[$];
   logic [127:0] rk_tab [0:15];
   int           alu_max = 0;
   int           rk_max = 0;
   int           alu_cnt = 0;
   int           rk_cnt = 0;
   int           done_cnt = 0;
   int           op_err = 0;
   int           rk_err = 0;
   int           last_mix = 0;
   logic [3:0]   cur_rnd = 4'd0;
   bit           abort_arm = 1'b0;
   bit           abort_fired = 1'b0;

   // ---------------- reference AES arithmetic ----------------
   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   // S-box as multiplicative inverse (x^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] base;
      logic [7:0] e;
      inv  = 8'h01;
      base = x;
      e    = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) inv = gmul(inv, base);
         base = gmul(base, base);
      end
      return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] s, input int i);
      return s[127-8*i -: 8];
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(gb(s, i));
      return r;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int row = 0; row < 4; row++)
         for (int c = 0; c < 4; c++)
            r[127-8*(row+4*c) -: 8] = gb(s, row + 4*((c+row) % 4));
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = gb(s, 4*c);
         a1 = gb(s, 4*c+1);
         a2 = gb(s, 4*c+2);
         a3 = gb(s, 4*c+3);
         r[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
         r[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
         r[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
         r[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
      return r;
   endfunction

   function automatic logic [127:0] alu_model(input logic [1:0] op,
                                              input logic [127:0] a,
                                              input logic [127:0] b);
      case (op)
         2'b00:   return a ^ b;
         2'b01:   return sub_bytes(a);
         2'b10:   return shift_rows(a);
         default: return mix_columns(a);
      endcase
   endfunction

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])}
                ^ {rcon, 24'h000000};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) rk_tab[r] = '0;
      for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Required op for the k-th ALU issue of a 10-round block
   function automatic logic [1:0] exp_op(input int k);
      if (k == 0) return 2'b00;
      if (k <= 36) begin
         case ((k - 1) % 4)
            0:       return 2'b01;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b00;
         endcase
      end
      if (k == 37) return 2'b01;
      if (k == 38) return 2'b10;
      return 2'b00;
   endfunction

   // ---------------- responders ----------------
   // Key-expansion model: answers each rk_req after 0..rk_max cycles
   initial begin : key_resp
      logic [3:0] rq;
      int         d;
      rk_valid = 1'b0;
      rk_in    = '0;
      forever begin
         @(negedge clk);
         rk_valid = 1'b0;
         if (rk_req === 1'b1) begin
            rq = rk_round;
            d  = int'($urandom_range(rk_max, 0));
            repeat (d) @(negedge clk);
            rk_in    = rk_tab[rq];
            rk_valid = 1'b1;
         end
      end
   end

   // ALU model: answers each alu_start after 1+(0..alu_max) cycles
   initial begin : alu_resp
      logic [127:0] r;
      int           d;
      alu_valid  = 1'b0;
      alu_result = '0;
      abort      = 1'b0;
      forever begin
         @(negedge clk);
         alu_valid = 1'b0;
         abort     = 1'b0;
         if (alu_start === 1'b1) begin
            r = alu_model(alu_op, alu_a, alu_b);
            d = int'($urandom_range(alu_max, 0));
            repeat (d + 1) @(negedge clk);
            alu_result = r;
            alu_valid  = 1'b1;
            if (abort_arm && cur_rnd == 4'd3) begin
               abort       = 1'b1;
               abort_arm   = 1'b0;
               abort_fired = 1'b1;
            end
         end
      end
   end

   // Protocol monitor: op sequence, key-request order, done pulses
   initial begin : monitor
      forever begin
         @(negedge clk);
         #1;
         if (alu_start === 1'b1) begin
            if (alu_op !== exp_op(alu_cnt)) op_err++;
            if (alu_cnt >= 37 && alu_op == 2'b11) last_mix++;
            alu_cnt++;
         end
         if (rk_req === 1'b1) cur_rnd = rk_round;
         if (rk_req === 1'b1 && rk_valid === 1'b1) begin
            if (rk_round !== 4'(rk_cnt)) rk_err++;
            rk_cnt++;
         end
         if (done === 1'b1) done_cnt++;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},      128'(busy),      128'd0);
      chk({tag, "_done"},      128'(done),      128'd0);
      chk({tag, "_rk_req"},    128'(rk_req),    128'd0);
      chk({tag, "_rk_round"},  128'(rk_round),  128'd0);
      chk({tag, "_alu_start"}, 128'(alu_start), 128'd0);
      chk({tag, "_alu_op"},    128'(alu_op),    128'd0);
      chk({tag, "_alu_a"},     alu_a,           128'd0);
      chk({tag, "_alu_b"},     alu_b,           128'd0);
      chk({tag, "_state_out"}, state_out,       128'd0);
   endtask

   task automatic launch(input vec_t v);
      expand_key(v.key);
      alu_max  = v.alu_dly;
      rk_max   = v.rk_dly;
      alu_cnt  = 0;
      rk_cnt   = 0;
      done_cnt = 0;
      op_err   = 0;
      rk_err   = 0;
      last_mix = 0;
      cur_rnd  = 4'd0;
      @(negedge clk);
      state_in = v.pt;
      start    = 1'b1;
      exp_q.push_back(v.ct);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("busy_after_start", 128'(busy), 128'd1);
   endtask

   task automatic finish_run(input string tag);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         @(negedge clk);
         #2;
         n++;
      end
      total++;
      if (done_cnt == 0) begin
         bad++;
         $display("FAIL %s_timeout: got=no done want=done within 3000 cycles", tag);
         return;
      end
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s_scoreboard: got=empty queue want=entry", tag);
         return;
      end
      chk({tag, "_state_out"}, state_out, exp_q.pop_front());
      repeat (4) @(negedge clk);
      #2;
      chk({tag, "_done_pulses"}, 128'(done_cnt), 128'd1);
      chk({tag, "_alu_issues"},  128'(alu_cnt),  128'd40);
      chk({tag, "_rk_handshk"},  128'(rk_cnt),   128'd11);
      chk({tag, "_op_seq_err"},  128'(op_err),   128'd0);
      chk({tag, "_rk_order_err"},128'(rk_err),   128'd0);
      chk({tag, "_final_mix"},   128'(last_mix), 128'd0);
      chk({tag, "_busy_end"},    128'(busy),     128'd0);
   endtask

   task automatic wait_round(input logic [3:0] target, input string tag);
      int n;
      n = 0;
      while (cur_rnd != target && n < 3000) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (cur_rnd != target) begin
         total++;
         bad++;
         $display("FAIL %s_wait_round: got=%0d want=%0d", tag, cur_rnd, target);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin : main
      vec_t vecs [0:2];
      int   n;
      vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734,
                  128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32, 0, 0};
      vecs[1] = '{128'h00112233445566778899aabbccddeeff,
                  128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 7, 5};
      vecs[2] = '{128'h3243f6a8885a308d313198a2e0370734,
                  128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32, 7, 5};

      rst_n    = 1'b0;
      start    = 1'b0;
      state_in = '0;
      for (int r = 0; r < 16; r++) rk_tab[r] = '0;
      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven blocks: fixed latency and randomized latencies
      for (int i = 0; i < 3; i++) begin
         launch(vecs[i]);
         finish_run($sformatf("vec%0d", i));
      end

      // start pulsed in round 5 must not disturb the running block
      launch(vecs[0]);
      wait_round(4'd5, "spur");
      @(negedge clk);
      state_in = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_run("spur");

      // abort together with alu_valid in round 3
      abort_fired = 1'b0;
      abort_arm   = 1'b1;
      launch(vecs[1]);
      n = 0;
      while (!abort_fired && n < 3000) begin
         @(negedge clk);
         n++;
      end
      abort_arm = 1'b0;
      if (!abort_fired) begin
         total++;
         bad++;
         $display("FAIL abort_fire: got=no abort want=abort in round 3");
      end else begin
         @(posedge clk);
         #1;
         chk("abort_busy",      128'(busy),      128'd0);
         chk("abort_done",      128'(done),      128'd0);
         chk("abort_rk_req",    128'(rk_req),    128'd0);
         chk("abort_alu_start", 128'(alu_start), 128'd0);
         chk("abort_state_out", state_out,       vecs[0].ct);
      end
      repeat (12) @(negedge clk);
      #2;
      chk("abort_no_done",        128'(done_cnt), 128'd0);
      chk("abort_state_out_hold", state_out,      vecs[0].ct);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      launch(vecs[1]);
      finish_run("post_abort");

      // reset pulse during round 7
      launch(vecs[0]);
      wait_round(4'd7, "midrst");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      repeat (12) @(negedge clk);
      launch(vecs[0]);
      finish_run("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
